// File: rtl/control_vuelo_pajarito_pkg.sv
// -----------------------------------------------------------------------------
// control_vuelo_pajarito_pkg
// Shared definitions for the bird-flight control stage:
//   - estado_t : rise/cooldown FSM state encoding
//   - *_DEF    : default values for the block parameters (25 MHz system clock)
//   - max_int  : elaboration-time helper used to size the shared FSM counter
// -----------------------------------------------------------------------------
package control_vuelo_pajarito_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SUBIENDO     = 2'd1,
    ENFRIAMIENTO = 2'd2
  } estado_t;

  localparam int TICK_DIV_DEF   = 625_000;  // 25 MHz / 625_000 = 40 Hz physics tick
  localparam int DEB_CYCLES_DEF = 250_000;  // 10 ms of stable input at 25 MHz
  localparam int RISE_TICKS_DEF = 3;
  localparam int COOL_TICKS_DEF = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/control_vuelo_pajarito_if.sv
// -----------------------------------------------------------------------------
// control_vuelo_pajarito_if
// Groups the control stage's inputs (raw buttons, game_over) and its outputs
// towards the movement stage (en_time_out, en_subiendo, pausa).
//   master : the control stage (consumes buttons/game_over, drives controls)
//   slave  : the environment (drives buttons/game_over, consumes controls)
// -----------------------------------------------------------------------------
interface control_vuelo_pajarito_if;

  logic btn_salto;    // raw flap button, active high, asynchronous
  logic btn_pausa;    // raw pause button, active high, asynchronous
  logic game_over;    // synchronous level, 1 = game ended
  logic en_time_out;  // one-cycle physics tick
  logic en_subiendo;  // registered rise window
  logic pausa;        // registered pause level

  modport master (
    input  btn_salto,
    input  btn_pausa,
    input  game_over,
    output en_time_out,
    output en_subiendo,
    output pausa
  );

  modport slave (
    output btn_salto,
    output btn_pausa,
    output game_over,
    input  en_time_out,
    input  en_subiendo,
    input  pausa
  );

endinterface

// File: rtl/control_vuelo_pajarito_antirrebote.sv
// -----------------------------------------------------------------------------
// control_vuelo_pajarito_antirrebote
// Button conditioner: 2-flop synchroniser, debouncer and press-pulse generator.
// The debounced level only follows the synchronised input after DEB_CYCLES
// consecutive cycles of disagreement; any agreement restarts the count.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous reset, active low
//   btn   in  raw asynchronous button, active high
//   pulso out one-cycle registered pulse on each 0->1 of the debounced level
// -----------------------------------------------------------------------------
module control_vuelo_pajarito_antirrebote
  import control_vuelo_pajarito_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulso
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] estable_cnt_r;
  logic          nivel_r;
  logic          nivel_d_r;
  logic          pulso_r;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: count consecutive disagreement cycles, flip the level on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estable_cnt_r <= CNT_ZERO;
      nivel_r       <= 1'b0;
    end else if (sync2_r != nivel_r) begin
      if (estable_cnt_r == CNT_LAST) begin
        estable_cnt_r <= CNT_ZERO;
        nivel_r       <= sync2_r;
      end else begin
        estable_cnt_r <= estable_cnt_r + CNT_ONE;
        nivel_r       <= nivel_r;
      end
    end else begin
      estable_cnt_r <= CNT_ZERO;
      nivel_r       <= nivel_r;
    end
  end

  // Registered rising-edge detector; releases produce nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nivel_d_r <= 1'b0;
      pulso_r   <= 1'b0;
    end else begin
      nivel_d_r <= nivel_r;
      pulso_r   <= nivel_r & ~nivel_d_r;
    end
  end

  assign pulso = pulso_r;

endmodule

// File: rtl/control_vuelo_pajarito.sv
// -----------------------------------------------------------------------------
// control_vuelo_pajarito
// Upstream control stage for the bird-movement block: physics tick divider,
// conditioned flap/pause buttons, pause toggle and the rise/cooldown FSM that
// turns each accepted flap press into a rise window of RISE_TICKS unpaused ticks.
// Ports:
//   clk  in     system clock
//   rst  in     asynchronous reset, active low
//   bus  master btn_salto/btn_pausa/game_over in; en_time_out/en_subiendo/pausa out
// -----------------------------------------------------------------------------
module control_vuelo_pajarito
  import control_vuelo_pajarito_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RISE_TICKS = RISE_TICKS_DEF,
  parameter int COOL_TICKS = COOL_TICKS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  control_vuelo_pajarito_if.master   bus
);

  // Tick divider constants
  localparam int             TW        = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0]  TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]  TICK_ONE  = TW'(1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TICK_PRE  = TW'(TICK_DIV - 2);

  // FSM counter is shared by the rise and cooldown phases
  localparam int             FW        = $clog2(max_int(RISE_TICKS, COOL_TICKS) + 1);
  localparam logic [FW-1:0]  FCNT_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0]  FCNT_ONE  = FW'(1);
  localparam logic [FW-1:0]  RISE_LOAD = FW'(RISE_TICKS);
  localparam logic [FW-1:0]  COOL_LOAD = FW'(COOL_TICKS);
  localparam bit             SIN_ENFRIAMIENTO = (COOL_TICKS == 0);

  logic [TW-1:0] tick_cnt_r;
  logic          en_time_out_r;
  logic          salto_pulso_s;
  logic          pausa_pulso_s;
  logic          pausa_r;
  estado_t       estado_r;
  estado_t       estado_n_s;
  logic [FW-1:0] cnt_r;
  logic [FW-1:0] cnt_n_s;
  logic          tick_activo_s;
  logic          en_subiendo_r;

  control_vuelo_pajarito_antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_ar_salto (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_salto),
    .pulso (salto_pulso_s)
  );

  control_vuelo_pajarito_antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_ar_pausa (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_pausa),
    .pulso (pausa_pulso_s)
  );

  // Free-running tick divider; the pulse is registered one count early so it
  // is high exactly while the count sits at TICK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r    <= TICK_ZERO;
      en_time_out_r <= 1'b0;
    end else begin
      if (tick_cnt_r == TICK_LAST) begin
        tick_cnt_r <= TICK_ZERO;
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_ONE;
      end
      en_time_out_r <= (tick_cnt_r == TICK_PRE);
    end
  end

  // Pause toggle; game_over forces it low and swallows presses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pausa_r <= 1'b0;
    end else if (bus.game_over) begin
      pausa_r <= 1'b0;
    end else if (pausa_pulso_s) begin
      pausa_r <= ~pausa_r;
    end else begin
      pausa_r <= pausa_r;
    end
  end

  // Rise/cooldown next-state logic. Only unpaused ticks advance the count, so a
  // pause freezes both state and counter.
  always_comb begin
    estado_n_s    = estado_r;
    cnt_n_s       = cnt_r;
    tick_activo_s = en_time_out_r & ~pausa_r;
    if (bus.game_over) begin
      estado_n_s = IDLE;
      cnt_n_s    = FCNT_ZERO;
    end else begin
      case (estado_r)
        IDLE: begin
          if (salto_pulso_s && !pausa_r) begin
            estado_n_s = SUBIENDO;
            cnt_n_s    = RISE_LOAD;
          end else begin
            estado_n_s = IDLE;
            cnt_n_s    = cnt_r;
          end
        end
        SUBIENDO: begin
          if (tick_activo_s) begin
            if (cnt_r == FCNT_ONE) begin
              if (SIN_ENFRIAMIENTO) begin
                estado_n_s = IDLE;
                cnt_n_s    = FCNT_ZERO;
              end else begin
                estado_n_s = ENFRIAMIENTO;
                cnt_n_s    = COOL_LOAD;
              end
            end else begin
              estado_n_s = SUBIENDO;
              cnt_n_s    = cnt_r - FCNT_ONE;
            end
          end else begin
            estado_n_s = SUBIENDO;
            cnt_n_s    = cnt_r;
          end
        end
        ENFRIAMIENTO: begin
          if (tick_activo_s) begin
            if (cnt_r == FCNT_ONE) begin
              estado_n_s = IDLE;
              cnt_n_s    = FCNT_ZERO;
            end else begin
              estado_n_s = ENFRIAMIENTO;
              cnt_n_s    = cnt_r - FCNT_ONE;
            end
          end else begin
            estado_n_s = ENFRIAMIENTO;
            cnt_n_s    = cnt_r;
          end
        end
        default: begin
          estado_n_s = IDLE;
          cnt_n_s    = FCNT_ZERO;
        end
      endcase
    end
  end

  // FSM state register; en_subiendo is registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_r      <= IDLE;
      cnt_r         <= FCNT_ZERO;
      en_subiendo_r <= 1'b0;
    end else begin
      estado_r      <= estado_n_s;
      cnt_r         <= cnt_n_s;
      en_subiendo_r <= (estado_n_s == SUBIENDO);
    end
  end

  assign bus.en_time_out = en_time_out_r;
  assign bus.en_subiendo = en_subiendo_r;
  assign bus.pausa       = pausa_r;

endmodule

// File: tb/tb_control_vuelo_pajarito.sv
// -----------------------------------------------------------------------------
// tb_control_vuelo_pajarito
// Directed scenarios plus a randomized phase. Every cycle the three outputs are
// compared against a reference built from the behavioural rules: tick from the
// cycle number, debounced levels from the recorded raw-input history, and the
// rise window as "ticks left to rise" / "ticks left to cool" counters.
// -----------------------------------------------------------------------------
module tb_control_vuelo_pajarito;

  localparam int TD   = 8;
  localparam int DB   = 4;
  localparam int RT   = 3;
  localparam int CT   = 2;
  localparam int MAXC = 8192;

  localparam int C_SUB1  = 0;
  localparam int C_SUB0  = 1;
  localparam int C_PAU1  = 2;
  localparam int C_PAU0  = 3;
  localparam int C_TICK  = 4;
  localparam int C_TSUB  = 5;

  logic clk = 1'b0;
  logic rst;

  control_vuelo_pajarito_if bus_if ();

  control_vuelo_pajarito #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DB),
    .RISE_TICKS (RT),
    .COOL_TICKS (CT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state (index = clock edges since reset release)
  bit rf [MAXC];
  bit rp [MAXC];
  bit df [MAXC];
  bit dp [MAXC];
  bit pf [MAXC];
  bit pp [MAXC];
  int k;
  int run_f, run_p;
  int rise_left, cool_left;
  bit pz;
  bit exp_tick, exp_sub, exp_pausa;

  // observation statistics
  int st_n, st_first, st_rises, st_rise_ticks;
  bit prev_sub;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, k);
    end
  endtask

  task automatic model_reset();
    k = 0; run_f = 0; run_p = 0; rise_left = 0; cool_left = 0; pz = 1'b0;
    rf[0] = 1'b0; rp[0] = 1'b0; df[0] = 1'b0; dp[0] = 1'b0; pf[0] = 1'b0; pp[0] = 1'b0;
    exp_tick = 1'b0; exp_sub = 1'b0; exp_pausa = 1'b0;
  endtask

  // Advance the reference by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit syn_f, syn_p, old_f, old_p, live;
    k++;
    if (k >= MAXC) begin
      $display("FAIL model_history: edge %0d beyond capacity %0d", k, MAXC);
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "history overflow");
    end
    rf[k] = bus_if.btn_salto;
    rp[k] = bus_if.btn_pausa;
    // the debouncer sees the raw value from two edges earlier
    syn_f = (k >= 2) ? rf[k-2] : 1'b0;
    syn_p = (k >= 2) ? rp[k-2] : 1'b0;
    if (syn_f != df[k-1]) begin
      run_f++;
      if (run_f == DB) begin df[k] = syn_f; run_f = 0; end
      else df[k] = df[k-1];
    end else begin
      run_f = 0; df[k] = df[k-1];
    end
    if (syn_p != dp[k-1]) begin
      run_p++;
      if (run_p == DB) begin dp[k] = syn_p; run_p = 0; end
      else dp[k] = dp[k-1];
    end else begin
      run_p = 0; dp[k] = dp[k-1];
    end
    old_f = (k >= 2) ? df[k-2] : 1'b0;
    old_p = (k >= 2) ? dp[k-2] : 1'b0;
    pf[k] = df[k-1] && !old_f;
    pp[k] = dp[k-1] && !old_p;
    // rise window: ticks are counted only if unpaused
    live = (((k - 1) % TD) == TD - 1) && !pz;
    if (bus_if.game_over) begin
      rise_left = 0; cool_left = 0;
    end else if (rise_left > 0) begin
      if (live) begin
        rise_left--;
        if (rise_left == 0) cool_left = CT;
      end
    end else if (cool_left > 0) begin
      if (live) cool_left--;
    end else if (pf[k-1] && !pz) begin
      rise_left = RT;
    end
    if (bus_if.game_over) pz = 1'b0;
    else if (pp[k-1]) pz = !pz;
    exp_tick  = ((k % TD) == TD - 1);
    exp_sub   = (rise_left > 0);
    exp_pausa = pz;
  endtask

  task automatic stats_clear();
    st_n = 0; st_first = -1; st_rises = 0; st_rise_ticks = 0;
    prev_sub = bus_if.en_subiendo;
  endtask

  // One clock: reference update at the edge, checks at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("en_time_out", bus_if.en_time_out, exp_tick);
    check("en_subiendo", bus_if.en_subiendo, exp_sub);
    check("pausa",       bus_if.pausa,       exp_pausa);
    st_n++;
    if (bus_if.en_subiendo === 1'b1 && !prev_sub) begin
      st_rises++;
      if (st_first < 0) st_first = st_n;
    end
    if (bus_if.en_time_out === 1'b1 && bus_if.en_subiendo === 1'b1 && bus_if.pausa === 1'b0)
      st_rise_ticks++;
    prev_sub = (bus_if.en_subiendo === 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      C_SUB1:  return bus_if.en_subiendo === 1'b1;
      C_SUB0:  return bus_if.en_subiendo === 1'b0;
      C_PAU1:  return bus_if.pausa === 1'b1;
      C_PAU0:  return bus_if.pausa === 1'b0;
      C_TICK:  return bus_if.en_time_out === 1'b1;
      C_TSUB:  return (bus_if.en_time_out === 1'b1) && (bus_if.en_subiendo === 1'b1);
      default: return 1'b0;
    endcase
  endfunction

  // Advance at least one cycle, then until the condition holds or the budget runs out.
  task automatic wait_cond(input int sel, input int budget, input string tag, output int took);
    took = 0;
    do begin
      cyc();
      took++;
    end while (!cond(sel) && took < budget);
    check(tag, cond(sel), 1);
  endtask

  initial begin
    int took;
    rst = 1'b0;
    bus_if.btn_salto = 1'b0;
    bus_if.btn_pausa = 1'b0;
    bus_if.game_over = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tick",  bus_if.en_time_out, 0);
    check("rst_sub",   bus_if.en_subiendo, 0);
    check("rst_pausa", bus_if.pausa,       0);
    rst = 1'b1;

    // 1. idle: ticks at cycles 7, 15, 23
    for (int i = 1; i <= 24; i++) begin
      cyc();
      check("t1_tick_pos", bus_if.en_time_out, (i == 7 || i == 15 || i == 23) ? 1 : 0);
    end

    // 2. long press: 8-cycle latency, exactly 3 rise ticks, single rise
    stats_clear();
    bus_if.btn_salto = 1'b1;
    run(20);
    bus_if.btn_salto = 1'b0;
    run(40);
    check("t2_latency",    st_first, 8);
    check("t2_rises",      st_rises, 1);
    check("t2_rise_ticks", st_rise_ticks, RT);

    // 3. glitches shorter than the debounce window
    stats_clear();
    for (int i = 0; i < 6; i++) begin
      bus_if.btn_salto = 1'b1; run(2);
      bus_if.btn_salto = 1'b0; run(2);
    end
    run(20);
    check("t3_glitch_rises", st_rises, 0);

    // 4. pause after the first rise tick, hold 5 ticks, resume
    stats_clear();
    bus_if.btn_salto = 1'b1;
    wait_cond(C_SUB1, 20, "t4_rise_start", took);
    wait_cond(C_TSUB, 20, "t4_first_tick", took);
    bus_if.btn_salto = 1'b0;
    bus_if.btn_pausa = 1'b1;
    wait_cond(C_PAU1, 20, "t4_pause_on", took);
    bus_if.btn_pausa = 1'b0;
    check("t4_sub_held", bus_if.en_subiendo, 1);
    for (int i = 0; i < 5; i++) wait_cond(C_TICK, 20, "t4_paused_tick", took);
    check("t4_sub_still", bus_if.en_subiendo, 1);
    bus_if.btn_pausa = 1'b1;
    wait_cond(C_PAU0, 20, "t4_pause_off", took);
    bus_if.btn_pausa = 1'b0;
    run(40);
    check("t4_rise_ticks", st_rise_ticks, RT);
    check("t4_rises",      st_rises, 1);

    // 5. press during cooldown is ignored, a later press works
    stats_clear();
    bus_if.btn_salto = 1'b1;
    wait_cond(C_SUB1, 20, "t5_rise1", took);
    bus_if.btn_salto = 1'b0;
    wait_cond(C_SUB0, 40, "t5_rise1_end", took);
    bus_if.btn_salto = 1'b1; run(10);
    bus_if.btn_salto = 1'b0; run(40);
    check("t5_cool_press", st_rises, 1);
    bus_if.btn_salto = 1'b1;
    wait_cond(C_SUB1, 20, "t5_rise2", took);
    bus_if.btn_salto = 1'b0;
    run(40);
    check("t5_rises",      st_rises, 2);
    check("t5_rise_ticks", st_rise_ticks, 2 * RT);

    // 6. game_over while rising and paused
    bus_if.btn_salto = 1'b1;
    wait_cond(C_SUB1, 20, "t6_rise", took);
    bus_if.btn_salto = 1'b0;
    bus_if.btn_pausa = 1'b1;
    wait_cond(C_PAU1, 20, "t6_pause_on", took);
    bus_if.btn_pausa = 1'b0;
    check("t6_sub_before", bus_if.en_subiendo, 1);
    bus_if.game_over = 1'b1;
    cyc();
    check("t6_go_sub",   bus_if.en_subiendo, 0);
    check("t6_go_pausa", bus_if.pausa, 0);
    bus_if.btn_salto = 1'b1; bus_if.btn_pausa = 1'b1; run(15);
    bus_if.btn_salto = 1'b0; bus_if.btn_pausa = 1'b0; run(15);
    bus_if.game_over = 1'b0;
    run(20);
    check("t6_after_sub",   bus_if.en_subiendo, 0);
    check("t6_after_pausa", bus_if.pausa, 0);

    // reset asserted mid-rise
    bus_if.btn_salto = 1'b1;
    wait_cond(C_SUB1, 20, "t6_rise_rst", took);
    bus_if.btn_salto = 1'b0;
    run(3);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_tick",  bus_if.en_time_out, 0);
    check("rst_mid_sub",   bus_if.en_subiendo, 0);
    check("rst_mid_pausa", bus_if.pausa, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(20);

    // randomized phase
    for (int s = 0; s < 60; s++) begin
      bus_if.btn_salto = 1'($urandom_range(0, 1));
      bus_if.btn_pausa = ($urandom_range(0, 3) == 0);
      bus_if.game_over = ($urandom_range(0, 9) == 0);
      run($urandom_range(1, 14));
    end
    bus_if.btn_salto = 1'b0;
    bus_if.btn_pausa = 1'b0;
    bus_if.game_over = 1'b0;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
